// File: rtl/lfo_pkg.sv
// Shared types and constants for the triangle-LFO controller slice.
// No logic; a state-decode helper is shared by RTL and bench.
package lfo_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STOP = 2'd1,
    S_ARM  = 2'd2,
    S_RUN  = 2'd3
  } lfo_state_e;

  typedef logic [2:0] freq_code_t;

  localparam int STOP_CYC_DEF = 2;
  localparam int MOD_W_DEF    = 16;

  // Mid-scale of the modulation range: the sample emitted whenever the LFO is not running.
  localparam logic signed [15:0] MOD_MID = 16'sh4000;

  function automatic logic cfg_ready_of(input lfo_state_e s);
    return (s == S_IDLE) || (s == S_RUN);
  endfunction

endpackage

// File: rtl/lfo_ctrl_if.sv
// Config, generator-drive and modulation-sample signals of lfo_ctrl.
// slave = controller view, master = driver/consumer view.
interface lfo_ctrl_if #(
  parameter int MOD_W = lfo_pkg::MOD_W_DEF
);
  import lfo_pkg::*;

  logic                    i_cfg_valid;
  logic                    o_cfg_ready;
  logic                    i_cfg_en;
  freq_code_t              i_cfg_freq;
  logic [1:0]              i_cfg_depth;

  logic                    o_gen_start;
  freq_code_t              o_gen_freq;
  logic signed [31:0]      i_gen_tri;

  logic                    i_sample_tick;
  logic                    o_mod_valid;
  logic                    i_mod_ready;
  logic signed [MOD_W-1:0] o_mod;
  logic                    o_overrun;
  logic                    o_running;

  modport slave (
    input  i_cfg_valid, i_cfg_en, i_cfg_freq, i_cfg_depth,
    input  i_gen_tri, i_sample_tick, i_mod_ready,
    output o_cfg_ready, o_gen_start, o_gen_freq,
    output o_mod_valid, o_mod, o_overrun, o_running
  );

  modport master (
    output i_cfg_valid, i_cfg_en, i_cfg_freq, i_cfg_depth,
    output i_gen_tri, i_sample_tick, i_mod_ready,
    input  o_cfg_ready, o_gen_start, o_gen_freq,
    input  o_mod_valid, o_mod, o_overrun, o_running
  );

endinterface

// File: rtl/lfo_sample_reg.sv
// Single-entry modulation sample holding register with valid/ready and sticky overrun.
// Load visible 1 cycle later; a load while full and not accepted overwrites and flags overrun.
module lfo_sample_reg #(
  parameter int MOD_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_ld,
  input  logic signed [MOD_W-1:0] i_ld_dat,
  input  logic                    i_rdy,
  input  logic                    i_clr_ovr,
  output logic                    o_vld,
  output logic signed [MOD_W-1:0] o_dat,
  output logic                    o_overrun
);

  localparam logic signed [MOD_W-1:0] MID = {2'b01, {(MOD_W-2){1'b0}}};

  logic                    vld_q, vld_d;
  logic signed [MOD_W-1:0] dat_q, dat_d;
  logic                    ovr_q, ovr_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    ovr_d = ovr_q;
    if (i_clr_ovr) begin
      ovr_d = 1'b0;
    end
    if (i_ld) begin
      vld_d = 1'b1;
      dat_d = i_ld_dat;
      // A set beats a simultaneous clear so an overwrite is never lost.
      if (vld_q && !i_rdy) begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && i_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= 1'b0;
      dat_q <= MID;
      ovr_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      ovr_q <= ovr_d;
    end
  end

  assign o_vld     = vld_q;
  assign o_dat     = dat_q;
  assign o_overrun = ovr_q;

endmodule

// File: rtl/lfo_ctrl.sv
// Triangle-LFO controller: stop/re-arm sequencer plus per-tick decimation to MOD_W-bit samples.
// Config ready only in S_IDLE/S_RUN; sample out 1 cycle after tick. Optional LFO_DEPTH_EN adds depth scaling.
module lfo_ctrl
  import lfo_pkg::*;
#(
  parameter int STOP_CYC = STOP_CYC_DEF,
  parameter int MOD_W    = MOD_W_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  lfo_ctrl_if.slave   bus
);

  localparam logic [3:0]              STOP_LAST = 4'(STOP_CYC - 1);
  localparam logic signed [MOD_W-1:0] MID       = {2'b01, {(MOD_W-2){1'b0}}};

  lfo_state_e              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    en_q, en_d;
  freq_code_t              freq_q, freq_d;
  logic                    start_q, start_d;
  logic                    cfg_acc;
  logic signed [MOD_W-1:0] tri_top;
  logic signed [MOD_W-1:0] scaled;
  logic signed [MOD_W-1:0] samp;
  logic                    unused_tri;

  assign bus.o_cfg_ready = cfg_ready_of(state_q);
  assign cfg_acc         = bus.i_cfg_valid & bus.o_cfg_ready;

  // Frequency and enable land together with the S_RUN->S_STOP transition, so the
  // generator always sees start low on the cycle its frequency input changes.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    en_d    = en_q;
    freq_d  = freq_q;
    if (cfg_acc) begin
      en_d   = bus.i_cfg_en;
      freq_d = bus.i_cfg_freq;
    end
    case (state_q)
      S_IDLE: if (cfg_acc && bus.i_cfg_en) state_d = S_ARM;
      S_STOP: begin
        if (cnt_q == STOP_LAST) begin
          state_d = en_q ? S_ARM : S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ARM:  state_d = S_RUN;
      S_RUN:  if (cfg_acc) state_d = S_STOP;
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_ARM) || (state_d == S_RUN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      freq_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      freq_q  <= freq_d;
      start_q <= start_d;
    end
  end

  assign tri_top    = bus.i_gen_tri[31 -: MOD_W];
  assign unused_tri = ^bus.i_gen_tri[31-MOD_W:0];

`ifdef LFO_DEPTH_EN
  logic [1:0]            depth_q, depth_d;
  logic signed [MOD_W:0] diff;
  logic signed [MOD_W:0] diff_sh;

  always_comb begin
    depth_d = depth_q;
    if (cfg_acc) begin
      depth_d = bus.i_cfg_depth;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Attenuate around mid-scale; one guard bit keeps the offset exact before the shift.
  always_comb begin
    diff    = {tri_top[MOD_W-1], tri_top} - {MID[MOD_W-1], MID};
    diff_sh = diff >>> depth_q;
    scaled  = MID + diff_sh[MOD_W-1:0];
  end
`else
  logic unused_depth;

  assign unused_depth = ^bus.i_cfg_depth;
  assign scaled       = tri_top;
`endif

  assign samp = (state_q == S_RUN) ? scaled : MID;

  lfo_sample_reg #(
    .MOD_W (MOD_W)
  ) u_sample_reg (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ld      (bus.i_sample_tick),
    .i_ld_dat  (samp),
    .i_rdy     (bus.i_mod_ready),
    .i_clr_ovr (cfg_acc),
    .o_vld     (bus.o_mod_valid),
    .o_dat     (bus.o_mod),
    .o_overrun (bus.o_overrun)
  );

  assign bus.o_gen_start = start_q;
  assign bus.o_gen_freq  = freq_q;
  assign bus.o_running   = (state_q == S_RUN);

endmodule

// File: tb/tb_lfo_ctrl.sv
// Directed bench for lfo_ctrl: sequencing, sampling handshake, overrun, mid-sequence reset.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_lfo_ctrl;
  import lfo_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  lfo_ctrl_if #(.MOD_W(16)) bus ();

  lfo_ctrl #(
    .STOP_CYC (2),
    .MOD_W    (16)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic en, input logic [2:0] freq, input logic [1:0] depth);
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_en    = en;
    bus.i_cfg_freq  = freq;
    bus.i_cfg_depth = depth;
    chk("cfg_rdy_pre", 32'(bus.o_cfg_ready), 32'd1);
    step();
    bus.i_cfg_valid = 1'b0;
  endtask

  task automatic sample(input logic [31:0] tri_v, input logic rdy);
    bus.i_gen_tri     = tri_v;
    bus.i_sample_tick = 1'b1;
    bus.i_mod_ready   = rdy;
    step();
    bus.i_sample_tick = 1'b0;
    bus.i_mod_ready   = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start"},   32'(bus.o_gen_start), 32'd0);
    chk({tag, "_freq"},    32'(bus.o_gen_freq),  32'd0);
    chk({tag, "_mod"},     32'($unsigned(bus.o_mod)), 32'($unsigned(MOD_MID)));
    chk({tag, "_valid"},   32'(bus.o_mod_valid), 32'd0);
    chk({tag, "_overrun"}, 32'(bus.o_overrun),   32'd0);
    chk({tag, "_running"}, 32'(bus.o_running),   32'd0);
    chk({tag, "_cfg_rdy"}, 32'(bus.o_cfg_ready), 32'd1);
  endtask

  initial begin
    bus.i_cfg_valid   = 1'b0;
    bus.i_cfg_en      = 1'b0;
    bus.i_cfg_freq    = '0;
    bus.i_cfg_depth   = '0;
    bus.i_gen_tri     = '0;
    bus.i_sample_tick = 1'b0;
    bus.i_mod_ready   = 1'b0;

    step();
    step();
    check_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // Start from idle: S_ARM then S_RUN.
    send_cfg(1'b1, 3'd3, 2'd0);
    chk("t1_freq",    32'(bus.o_gen_freq),  32'd3);
    chk("t1_start",   32'(bus.o_gen_start), 32'd1);
    chk("t1_run_arm", 32'(bus.o_running),   32'd0);
    chk("t1_rdy_arm", 32'(bus.o_cfg_ready), 32'd0);
    step();
    chk("t1_running", 32'(bus.o_running),   32'd1);
    chk("t1_start2",  32'(bus.o_gen_start), 32'd1);
    chk("t1_rdy_run", 32'(bus.o_cfg_ready), 32'd1);

    // Retune while running: two stop cycles, new freq before start re-rises.
    send_cfg(1'b1, 3'd5, 2'd0);
    chk("t2_start_s0", 32'(bus.o_gen_start), 32'd0);
    chk("t2_freq_s0",  32'(bus.o_gen_freq),  32'd5);
    chk("t2_rdy_s0",   32'(bus.o_cfg_ready), 32'd0);
    chk("t2_run_s0",   32'(bus.o_running),   32'd0);
    step();
    chk("t2_start_s1", 32'(bus.o_gen_start), 32'd0);
    chk("t2_rdy_s1",   32'(bus.o_cfg_ready), 32'd0);
    step();
    chk("t2_start_arm", 32'(bus.o_gen_start), 32'd1);
    chk("t2_rdy_arm",   32'(bus.o_cfg_ready), 32'd0);
    chk("t2_run_arm",   32'(bus.o_running),   32'd0);
    step();
    chk("t2_running", 32'(bus.o_running),   32'd1);
    chk("t2_rdy_run", 32'(bus.o_cfg_ready), 32'd1);

    // Sample with ready high.
    sample(32'h2000_1234, 1'b1);
    chk("t3_mod",   32'($unsigned(bus.o_mod)), 32'h2000);
    chk("t3_valid", 32'(bus.o_mod_valid), 32'd1);
    bus.i_mod_ready = 1'b1;
    step();
    bus.i_mod_ready = 1'b0;
    chk("t3_valid_clr", 32'(bus.o_mod_valid), 32'd0);
    chk("t3_mod_hold",  32'($unsigned(bus.o_mod)), 32'h2000);

    // Overwrite without consumer.
    sample(32'h1111_0000, 1'b0);
    chk("t4_mod1",  32'($unsigned(bus.o_mod)), 32'h1111);
    chk("t4_ovr1",  32'(bus.o_overrun), 32'd0);
    sample(32'h2222_0000, 1'b0);
    chk("t4_ovr2",  32'(bus.o_overrun), 32'd1);
    chk("t4_mod2",  32'($unsigned(bus.o_mod)), 32'h2222);
    chk("t4_valid", 32'(bus.o_mod_valid), 32'd1);
    step();
    chk("t4_mod_stable", 32'($unsigned(bus.o_mod)), 32'h2222);

    // Same frequency re-sent: overrun clears, full stop/re-arm still happens.
    send_cfg(1'b1, 3'd5, 2'd0);
    chk("t4_ovr_clr",    32'(bus.o_overrun),   32'd0);
    chk("t4_restart",    32'(bus.o_gen_start), 32'd0);
    chk("t4_valid_kept", 32'(bus.o_mod_valid), 32'd1);
    step();
    step();
    chk("t4_arm_start", 32'(bus.o_gen_start), 32'd1);
    chk("t4_arm_run",   32'(bus.o_running),   32'd0);
    step();
    chk("t4_running", 32'(bus.o_running), 32'd1);

    // Tick coinciding with accept: stays valid, no overrun.
    sample(32'h3333_0000, 1'b1);
    chk("t4_coin_valid", 32'(bus.o_mod_valid), 32'd1);
    chk("t4_coin_mod",   32'($unsigned(bus.o_mod)), 32'h3333);
    chk("t4_coin_ovr",   32'(bus.o_overrun), 32'd0);
    bus.i_mod_ready = 1'b1;
    step();
    bus.i_mod_ready = 1'b0;
    chk("t4_coin_clr", 32'(bus.o_mod_valid), 32'd0);

    // Disable: stop then idle; ticks outside S_RUN give mid-scale.
    send_cfg(1'b0, 3'd5, 2'd0);
    chk("t5_start_s0", 32'(bus.o_gen_start), 32'd0);
    chk("t5_run_s0",   32'(bus.o_running),   32'd0);
    chk("t5_rdy_s0",   32'(bus.o_cfg_ready), 32'd0);
    sample(32'h7777_0000, 1'b0);
    chk("t5_mod_stop", 32'($unsigned(bus.o_mod)), 32'h4000);
    chk("t5_rdy_s1",   32'(bus.o_cfg_ready), 32'd0);
    step();
    chk("t5_idle_rdy",   32'(bus.o_cfg_ready), 32'd1);
    chk("t5_idle_start", 32'(bus.o_gen_start), 32'd0);
    chk("t5_idle_run",   32'(bus.o_running),   32'd0);
    bus.i_mod_ready = 1'b1;
    step();
    bus.i_mod_ready = 1'b0;
    chk("t5_drain", 32'(bus.o_mod_valid), 32'd0);
    sample(32'h7777_0000, 1'b0);
    chk("t5_mod_idle", 32'($unsigned(bus.o_mod)), 32'h4000);
    chk("t5_val_idle", 32'(bus.o_mod_valid), 32'd1);

    // Disable while idle: frequency loads, nothing starts.
    send_cfg(1'b0, 3'd1, 2'd0);
    chk("t5_noop_freq",  32'(bus.o_gen_freq),  32'd1);
    chk("t5_noop_start", 32'(bus.o_gen_start), 32'd0);
    step();
    chk("t5_noop_run", 32'(bus.o_running),   32'd0);
    chk("t5_noop_rdy", 32'(bus.o_cfg_ready), 32'd1);

    send_cfg(1'b1, 3'd2, 2'd2);
    step();
    chk("t6_running", 32'(bus.o_running), 32'd1);
`ifdef LFO_DEPTH_EN
    sample(32'h0000_5555, 1'b1);
    chk("t6_depth_zero", 32'($unsigned(bus.o_mod)), 32'h3000);
    sample(32'h7FFF_0000, 1'b1);
    chk("t6_depth_max",  32'($unsigned(bus.o_mod)), 32'h4FFF);
    sample(32'h8000_0000, 1'b1);
    chk("t6_depth_min",  32'($unsigned(bus.o_mod)), 32'h1000);
`else
    sample(32'h7FFF_0000, 1'b1);
    chk("t6_full_max", 32'($unsigned(bus.o_mod)), 32'h7FFF);
    sample(32'h8000_0000, 1'b1);
    chk("t6_full_min", 32'($unsigned(bus.o_mod)), 32'h8000);
`endif

    // Build up state, then reset asynchronously in the middle of S_STOP.
    sample(32'h5555_0000, 1'b0);
    chk("t7_ovr_set", 32'(bus.o_overrun), 32'd1);
    send_cfg(1'b1, 3'd6, 2'd0);
    chk("t7_ovr_clr", 32'(bus.o_overrun), 32'd0);
    sample(32'h1234_0000, 1'b0);
    chk("t7_ovr_stop", 32'(bus.o_overrun),   32'd1);
    chk("t7_freq",     32'(bus.o_gen_freq),  32'd6);
    chk("t7_rdy_stop", 32'(bus.o_cfg_ready), 32'd0);
    rst_n = 1'b0;
    #2;
    check_reset_vals("rst_mid");
    step();
    rst_n = 1'b1;
    step();
    send_cfg(1'b1, 3'd4, 2'd0);
    chk("t7_rearm_freq",  32'(bus.o_gen_freq),  32'd4);
    chk("t7_rearm_start", 32'(bus.o_gen_start), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
